// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick rate scheduler.
//   NCH_DEF / W_DEF : default channel count and phase/step width
//   CH_W            : channel index width for the default channel count
//   cfg_entry_t     : one configuration request {ch, step, en} at default widths
//   ch_width()      : channel index width for an arbitrary channel count
package tick_sched_pkg;

  localparam int unsigned NCH_DEF = 4;
  localparam int unsigned W_DEF   = 32;
  localparam int unsigned CH_W    = $clog2(NCH_DEF);

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [W_DEF-1:0] step;
    logic             en;
  } cfg_entry_t;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_cfg_hold.sv
// One-entry valid/ready holding register for configuration requests.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : request present
//   in_ready   : entry free (low while rst is high or an entry is pending)
//   in_data    : request payload, captured on valid & ready
//   apply      : pending entry consumed this cycle
//   pend_v     : an entry is pending
//   pend_data  : captured payload, stable while pend_v is high
module tick_cfg_hold
  import tick_sched_pkg::*;
#(
  parameter int unsigned DW = $bits(cfg_entry_t)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          apply,
  output logic          pend_v,
  output logic [DW-1:0] pend_data
);

  assign in_ready = ~pend_v & ~rst;

  // Accept and apply never coincide: in_ready is low whenever apply can fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v    <= 1'b0;
      pend_data <= '0;
    end else if (in_valid && in_ready) begin
      pend_v    <= 1'b1;
      pend_data <= in_data;
    end else if (apply) begin
      pend_v    <= 1'b0;
    end
  end

endmodule

// File: rtl/tick_rate_scheduler.sv
// Time-multiplexed phase-accumulator tick generator. One shared W-bit adder is
// round-robin scheduled over NCH channels; each channel produces a tick strobe
// and a square wave at f_clk*step/(NCH*2^W).
//   clk, rst   : clock, synchronous active-high reset
//   cfg_valid  : config request; cfg_ready : request accepted when both high
//   cfg_ch     : target channel; cfg_step : new step; cfg_en : enable/disable
//   cfg_done   : 1-cycle pulse when the pending config has been applied
//   tick       : per-channel 1-cycle pulse on accumulator carry-out
//   clk_out    : per-channel phase MSB (~50% duty square wave)
module tick_rate_scheduler
  import tick_sched_pkg::*;
#(
  parameter  int unsigned NCH    = NCH_DEF,
  parameter  int unsigned W      = W_DEF,
  localparam int unsigned SLOT_W = ch_width(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [SLOT_W-1:0] cfg_ch,
  input  logic [W-1:0]      cfg_step,
  input  logic              cfg_en,
  output logic              cfg_done,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    clk_out
);

  typedef struct packed {
    logic [SLOT_W-1:0] ch;
    logic [W-1:0]      step;
    logic              en;
  } entry_t;

  entry_t cfg_in;
  entry_t pend;
  logic   pend_v;

  logic [SLOT_W-1:0] slot;
  logic [W-1:0]      phase  [NCH];
  logic [W-1:0]      step_r [NCH];
  logic [NCH-1:0]    en;

  logic [W-1:0] cur_phase;
  logic [W-1:0] cur_step;
  logic         cur_en;
  logic [W:0]   sum;
  logic         carry;
  logic         hit;
  logic         cond_dis;
  logic         cond_fresh;
  logic         apply;

  assign cfg_in = '{ch: cfg_ch, step: cfg_step, en: cfg_en};

  tick_cfg_hold #(
    .DW($bits(entry_t))
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (cfg_valid),
    .in_ready  (cfg_ready),
    .in_data   (cfg_in),
    .apply     (apply),
    .pend_v    (pend_v),
    .pend_data (pend)
  );

  // Shared adder serves only the channel owning the current slot.
  assign cur_phase = phase[slot];
  assign cur_step  = step_r[slot];
  assign cur_en    = en[slot];
  assign sum       = {1'b0, cur_phase} + {1'b0, cur_step};
  assign carry     = sum[W];

  // A running channel is only reprogrammed on its carry slot, so every
  // emitted period is a whole period of either the old or the new step.
  // A channel index >= NCH never matches a slot and stays pending.
  assign hit        = pend_v && (pend.ch == slot);
  assign cond_dis   = ~pend.en;
  assign cond_fresh = ~cur_en || (cur_step == '0);
  assign apply      = hit && (cond_dis || cond_fresh || carry);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= '0;
      en       <= '0;
      tick     <= '0;
      clk_out  <= '0;
      cfg_done <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        phase[c]  <= '0;
        step_r[c] <= '0;
      end
    end else begin
      slot     <= (slot == SLOT_W'(NCH - 1)) ? '0 : slot + 1'b1;
      tick     <= '0;
      cfg_done <= apply;

      if (apply && cond_dis) begin
        en[slot]      <= 1'b0;
        phase[slot]   <= '0;
        step_r[slot]  <= pend.step;
        clk_out[slot] <= 1'b0;
      end else if (apply && cond_fresh) begin
        // Fresh start from phase 0; this slot does not accumulate.
        en[slot]      <= 1'b1;
        phase[slot]   <= '0;
        step_r[slot]  <= pend.step;
        clk_out[slot] <= 1'b0;
      end else if (cur_en) begin
        // Carry-slot apply still emits the tick and keeps the wrapped sum;
        // the new step takes effect from the next slot.
        phase[slot]   <= sum[W-1:0];
        tick[slot]    <= carry;
        clk_out[slot] <= sum[W-1];
        if (apply) begin
          step_r[slot] <= pend.step;
        end
      end
    end
  end

endmodule
